// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan controller and its decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_pkg;

  // Active-low segment word with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low anode word with every anode off. It is sized for the widest
  // supported display (8 digits); users slice it to their digit count.
  localparam logic [7:0] AN_OFF = 8'hFF;

  // One hexadecimal display digit.
  typedef logic [3:0] hex_t;

  // Width of a digit index. A single-digit display still gets a 1-bit index
  // so that no zero-width vectors are ever declared.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex digit to active-low 7-segment pattern decoder (0-9, A, b, C, d, E, F).
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input.
// Ports: digit - 4-bit hex value; seg - active-low segments, seg[0] = a ... seg[6] = g.
module hex7seg
  import seg7_pkg::*;
(
  input  hex_t       digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered value and leading-zero blanking.
// Latency: seg/dp/an/frame_tick are registered, one cycle behind the prescaler/index state.
// Backpressure: none; load is always accepted, last load before a frame boundary wins.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   en                scan enable (prescaler/index hold while low, anodes off)
//   load, value, dp_in  strobe capturing digits and decimal points into the pending buffer
//   lzb               leading-zero blanking enable
//   seg, dp, an       active-low segments, decimal point and anodes
//   frame_tick        one-cycle pulse the cycle after each frame boundary
//   pending           a loaded value is waiting for the next frame boundary
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzb,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick,
  output logic                    pending
);
  import seg7_pkg::*;

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANS_OFF   = AN_OFF[NUM_DIGITS-1:0];

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] act_val;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;

  logic                    cnt_last;
  logic                    boundary;
  logic                    in_blank;
  hex_t                    cur_digit;
  logic                    cur_dp;
  logic                    cur_lz;
  logic                    zero_above;
  logic [NUM_DIGITS-1:0]   an_act;
  logic [6:0]              dec_seg;

  assign cnt_last = (cnt == CNT_LAST);
  // A frame only ends while scanning; a held scan never produces a boundary.
  assign boundary = en && cnt_last && (idx == IDX_LAST);
  assign in_blank = (cnt < BLANK_END);

  // Select the digit being scanned. Walking from the most significant digit
  // down lets zero_above track "this digit and all higher digits are zero"
  // for leading-zero blanking in the same pass.
  always_comb begin
    cur_digit  = '0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    an_act     = ANS_OFF;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (act_val[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        cur_digit = act_val[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_lz    = lzb && (i != 0) && zero_above;
        an_act[i] = 1'b0;
      end
    end
  end

  hex7seg u_hex7seg (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      an         <= ANS_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
    end else begin
      if (en) begin
        cnt <= cnt_last ? '0 : cnt + 1'b1;
        if (cnt_last) begin
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end

      // The transfer reads the pending buffer as it stood before this edge,
      // so a load on the boundary cycle is held for the following frame.
      if (boundary && pending) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end

      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pending  <= 1'b1;
      end else if (boundary) begin
        pending  <= 1'b0;
      end

      frame_tick <= boundary;

      if (!en || in_blank) begin
        an  <= ANS_OFF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else begin
        an  <= an_act;
        seg <= cur_lz ? SEG_BLANK : dec_seg;
        dp  <= ~cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scenarios plus randomized traffic vs. a frame-position model.
// Latency: model predicts each registered output one clock after the inputs it depends on.
// Backpressure: n/a.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int RDIV  = 8;
  localparam int BLK   = 2;
  localparam int FRAME = ND * RDIV;

  localparam logic [6:0] SEGTBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lzb;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;
  logic        pending;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RDIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .lzb        (lzb),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: position within the frame as a plain cycle count
  // (0..FRAME-1), plus the displayed and waiting values.
  int          m_pos;
  logic [15:0] m_act;
  logic [3:0]  m_act_dp;
  logic [15:0] m_pv;
  logic [3:0]  m_pdp;
  logic        m_pend;

  // Per-frame observations for the directed checks.
  logic [6:0]  rec_seg [ND];
  logic        rec_dp  [ND];
  int          blank_cnt;
  int          one_cnt;
  int          ft_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    for (int i = 0; i < ND; i++) begin
      rec_seg[i] = 7'h55;
      rec_dp[i]  = 1'bx;
    end
    blank_cnt = 0;
    one_cnt   = 0;
    ft_cnt    = 0;
  endtask

  // Advance one clock with the currently driven inputs and compare every
  // output against the model's prediction.
  task automatic step();
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_ft;
    logic        e_pend;
    logic        chk_sd;
    logic [15:0] sh;
    logic [3:0]  dsh;
    int          slot;
    int          c;
    chk_sd = 1'b1;
    e_an   = 4'hF;
    e_seg  = 7'h7F;
    e_dp   = 1'b1;
    e_ft   = 1'b0;
    if (!rst_n) begin
      m_pos    = 0;
      m_act    = '0;
      m_act_dp = '0;
      m_pv     = '0;
      m_pdp    = '0;
      m_pend   = 1'b0;
      e_pend   = 1'b0;
    end else begin
      slot = m_pos / RDIV;
      c    = m_pos % RDIV;
      e_ft = en && (m_pos == FRAME - 1);
      if (!en) begin
        chk_sd = 1'b0;
      end else if (c >= BLK) begin
        e_an  = 4'hF ^ (4'h1 << slot);
        sh    = m_act >> (4 * slot);
        e_seg = (lzb && slot != 0 && sh == 16'h0) ? 7'h7F : SEGTBL[sh[3:0]];
        dsh   = m_act_dp >> slot;
        e_dp  = ~dsh[0];
      end
      if (e_ft && m_pend) begin
        m_act    = m_pv;
        m_act_dp = m_pdp;
      end
      if (load) begin
        m_pv   = value;
        m_pdp  = dp_in;
        m_pend = 1'b1;
      end else if (e_ft) begin
        m_pend = 1'b0;
      end
      e_pend = m_pend;
      if (en) m_pos = (m_pos + 1) % FRAME;
    end

    @(posedge clk);
    #1;
    check("an", 32'(an), 32'(e_an));
    check("frame_tick", 32'(frame_tick), 32'(e_ft));
    check("pending", 32'(pending), 32'(e_pend));
    if (chk_sd) begin
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
    end

    if (an == 4'hF) blank_cnt++;
    for (int i = 0; i < ND; i++) begin
      if (an == (4'hF ^ (4'h1 << i))) begin
        one_cnt++;
        rec_seg[i] = seg;
        rec_dp[i]  = dp;
      end
    end
    if (frame_tick) ft_cnt++;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic wait_ft(input string tag);
    logic got;
    got = 1'b0;
    for (int k = 0; k < FRAME + 8; k++) begin
      step();
      if (frame_tick) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, 32'(got), 32'd1);
  endtask

  task automatic record_frame();
    clear_rec();
    for (int k = 0; k < FRAME; k++) step();
  endtask

  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    check({tag, "_d0"}, 32'(rec_seg[0]), 32'(s0));
    check({tag, "_d1"}, 32'(rec_seg[1]), 32'(s1));
    check({tag, "_d2"}, 32'(rec_seg[2]), 32'(s2));
    check({tag, "_d3"}, 32'(rec_seg[3]), 32'(s3));
  endtask

  task automatic step_to_pos(input int p);
    for (int k = 0; k < FRAME + 8; k++) begin
      if (m_pos == p) break;
      step();
    end
    check("reach_pos", 32'(m_pos), 32'(p));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    value = '0;
    dp_in = '0;
    lzb   = 1'b0;
    clear_rec();

    // Reset state.
    for (int k = 0; k < 3; k++) step();
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_ft", 32'(frame_tick), 32'd0);

    // Basic scan of 1234 with dp on digit 0.
    rst_n = 1'b1;
    en    = 1'b1;
    for (int k = 0; k < 5; k++) step();
    do_load(16'h1234, 4'b0001);
    check("load_pending", 32'(pending), 32'd1);
    wait_ft("first_boundary");
    check("xfer_pending_clr", 32'(pending), 32'd0);
    record_frame();
    check_frame("scan1234", 7'h19, 7'h30, 7'h24, 7'h79);
    check("scan_dp0", 32'(rec_dp[0]), 32'd0);
    check("scan_dp1", 32'(rec_dp[1]), 32'd1);
    check("scan_dp2", 32'(rec_dp[2]), 32'd1);
    check("scan_dp3", 32'(rec_dp[3]), 32'd1);
    check("blank_cycles", 32'(blank_cnt), 32'(ND * BLK));
    check("lit_cycles", 32'(one_cnt), 32'(ND * (RDIV - BLK)));
    check("ticks_per_frame", 32'(ft_cnt), 32'd1);

    // Leading-zero blanking.
    lzb = 1'b1;
    do_load(16'h0070, 4'b0000);
    wait_ft("lzb_a_boundary");
    record_frame();
    check_frame("lzb_0070", 7'h40, 7'h78, 7'h7F, 7'h7F);
    do_load(16'h0000, 4'b0000);
    wait_ft("lzb_b_boundary");
    record_frame();
    check_frame("lzb_0000", 7'h40, 7'h7F, 7'h7F, 7'h7F);
    do_load(16'h0700, 4'b0000);
    wait_ft("lzb_c_boundary");
    record_frame();
    check_frame("lzb_0700", 7'h40, 7'h40, 7'h78, 7'h7F);
    lzb = 1'b0;

    // Two loads in one frame: last one wins.
    do_load(16'h1111, 4'b0000);
    for (int k = 0; k < 3; k++) step();
    do_load(16'h2222, 4'b0000);
    wait_ft("collide_boundary");
    record_frame();
    check_frame("last_wins", 7'h24, 7'h24, 7'h24, 7'h24);

    // Load exactly on the boundary cycle.
    do_load(16'h5555, 4'b0000);
    step_to_pos(FRAME - 1);
    do_load(16'h6666, 4'b0000);
    check("bnd_load_ft", 32'(frame_tick), 32'd1);
    check("bnd_load_pending", 32'(pending), 32'd1);
    record_frame();
    check_frame("bnd_old", 7'h12, 7'h12, 7'h12, 7'h12);
    check("bnd_pending_after", 32'(pending), 32'd0);
    record_frame();
    check_frame("bnd_new", 7'h02, 7'h02, 7'h02, 7'h02);

    // Enable gating mid-slot 2.
    step_to_pos(2 * RDIV + 4);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("en_off_an", 32'(an), 32'hF);
      check("en_off_ft", 32'(frame_tick), 32'd0);
    end
    en = 1'b1;
    step();
    check("en_resume_an", 32'(an), 32'hB);
    n = 1;
    while (!frame_tick && n < FRAME + 8) begin
      step();
      n++;
    end
    check("en_resume_len", 32'(n), 32'd12);

    // Reset in the middle of a scan, with a load pending.
    do_load(16'h9999, 4'b1111);
    step_to_pos(13);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("mrst_an", 32'(an), 32'hF);
    check("mrst_seg", 32'(seg), 32'h7F);
    check("mrst_dp", 32'(dp), 32'd1);
    check("mrst_pending", 32'(pending), 32'd0);
    check("mrst_ft", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("mrst_restart_d0", 32'(an), 32'hE);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom % 300) != 0;
      en    = ($urandom % 10) != 0;
      load  = ($urandom % 12) == 0;
      value = 16'($urandom) >> (4 * $urandom_range(0, 3));
      dp_in = 4'($urandom);
      lzb   = 1'($urandom);
      step();
    end
    load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
